// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer and its
// branch-target table.
package pc_pkg;
    localparam int PC_W_DEF  = 10;
    localparam int TGT_W_DEF = 8;
    localparam int TBL_DEPTH = 16;
    localparam int SEL_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Power-on contents of the branch-target table.
    function automatic int tgt_reset(input int idx);
        case (idx)
            1:       return 1;
            2:       return 30;
            3:       return 31;
            default: return 0;
        endcase
    endfunction
endpackage

// File: rtl/branch_target_table.sv
// 16-entry branch-target register file: one synchronous write port and one
// combinational read port, asynchronously reset to the package constants.
module branch_target_table
    import pc_pkg::*;
#(
    parameter int TGT_W = TGT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [SEL_W-1:0] waddr,
    input  logic [TGT_W-1:0] wdata,
    input  logic [SEL_W-1:0] raddr,
    output logic [TGT_W-1:0] rdata
);
    logic [TBL_DEPTH-1:0][TGT_W-1:0] tbl_q, tbl_d;

    always_comb begin
        tbl_d = tbl_q;
        if (we) tbl_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= TGT_W'(tgt_reset(i));
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Read the registered contents so a same-cycle write is not seen.
    assign rdata = tbl_q[raddr];
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, next-PC mux with
// step/stall/absolute and relative branches through the target table.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int TGT_W    = TGT_W_DEF,
    parameter int START_PC = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchAbs,
    input  logic [SEL_W-1:0] BranchSel,
    input  logic             TgtWe,
    input  logic [SEL_W-1:0] TgtAddr,
    input  logic [TGT_W-1:0] TgtData,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done
);
    localparam logic [PC_W-1:0] START = PC_W'(START_PC);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [TGT_W-1:0] tgt;

    branch_target_table #(.TGT_W(TGT_W)) u_tbl (
        .clk   (Clk),
        .rst   (Reset),
        .we    (TgtWe),
        .waddr (TgtAddr),
        .wdata (TgtData),
        .raddr (BranchSel),
        .rdata (tgt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = START;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (BranchEn) begin
                    // Relative offsets are signed; the sum wraps at PC_W bits.
                    pc_d = BranchAbs ? PC_W'(tgt) : pc_q + PC_W'($signed(tgt));
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= START;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign PC      = pc_q;
    assign Running = running_q;
    assign Done    = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a cycle-level
// behavioural model of the program counter and its target table.
module tb_pc_sequencer;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start, Halt, Stall, BranchEn, BranchAbs, TgtWe;
    logic [3:0] BranchSel, TgtAddr;
    logic [7:0] TgtData;
    logic [9:0] PC;
    logic       Running, Done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = idle, 1 = running, 2 = finished.
    int m_pc, m_mode;
    int m_tbl[16];

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
        .BranchEn(BranchEn), .BranchAbs(BranchAbs), .BranchSel(BranchSel),
        .TgtWe(TgtWe), .TgtAddr(TgtAddr), .TgtData(TgtData),
        .PC(PC), .Running(Running), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_mode = 0;
        foreach (m_tbl[i]) m_tbl[i] = 0;
        m_tbl[1] = 1;
        m_tbl[2] = 30;
        m_tbl[3] = 31;
    endtask

    task automatic model_step();
        int t, off;
        t = m_tbl[BranchSel];
        off = (t >= 128) ? t - 256 : t;
        if (m_mode != 1) begin
            if (Start) begin
                m_mode = 1;
                m_pc = 0;
            end
        end else if (Halt) begin
            m_mode = 2;
        end else if (Stall) begin
            m_pc = m_pc;
        end else if (BranchEn) begin
            m_pc = BranchAbs ? t : ((m_pc + off) & 1023);
        end else begin
            m_pc = (m_pc + 1) & 1023;
        end
        if (TgtWe) m_tbl[TgtAddr] = TgtData;
    endtask

    task automatic clear_inputs();
        Start = 0; Halt = 0; Stall = 0; BranchEn = 0; BranchAbs = 0;
        BranchSel = 0; TgtWe = 0; TgtAddr = 0; TgtData = 0;
    endtask

    // One clock: advance the model, take the edge, compare all outputs.
    task automatic step(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check({tag, "_pc"}, 32'(PC), 32'(m_pc));
        check({tag, "_running"}, 32'(Running), 32'(m_mode == 1));
        check({tag, "_done"}, 32'(Done), 32'(m_mode == 2));
        clear_inputs();
    endtask

    // Park the PC at n via table entry 15 and an absolute branch.
    task automatic jump_to(input int n);
        TgtWe = 1; TgtAddr = 15; TgtData = 8'(n); Stall = 1;
        step("jmp_wr");
        BranchEn = 1; BranchAbs = 1; BranchSel = 15;
        step("jmp_br");
        check("jmp_target", 32'(PC), n);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #12 Reset = 0;
        check("rst_pc", 32'(PC), 0);
        check("rst_running", 32'(Running), 0);
        check("rst_done", 32'(Done), 0);

        step("idle_hold");
        check("idle_pc", 32'(PC), 0);

        Start = 1;
        step("start");
        check("start_running", 32'(Running), 1);
        check("start_pc", 32'(PC), 0);
        for (int i = 1; i <= 10; i++) begin
            step("incr");
            check("incr_pc", 32'(PC), i);
        end

        BranchEn = 1; BranchAbs = 1; BranchSel = 2;
        step("abs_sel2");
        check("abs_sel2_pc", 32'(PC), 30);
        jump_to(10);
        BranchEn = 1; BranchAbs = 0; BranchSel = 3;
        step("rel_sel3");
        check("rel_sel3_pc", 32'(PC), 41);

        TgtWe = 1; TgtAddr = 5; TgtData = 8'hFE;
        step("wr5");
        jump_to(20);
        BranchEn = 1; BranchSel = 5;
        step("rel_neg");
        check("rel_neg_pc", 32'(PC), 18);
        jump_to(1);
        BranchEn = 1; BranchSel = 5;
        step("rel_wrap");
        check("rel_wrap_pc", 32'(PC), 1023);
        step("incr_wrap");
        check("incr_wrap_pc", 32'(PC), 0);

        TgtWe = 1; TgtAddr = 2; TgtData = 50;
        BranchEn = 1; BranchAbs = 1; BranchSel = 2;
        step("rbw_old");
        check("rbw_old_pc", 32'(PC), 30);
        BranchEn = 1; BranchAbs = 1; BranchSel = 2;
        step("rbw_new");
        check("rbw_new_pc", 32'(PC), 50);

        jump_to(7);
        Halt = 1; Stall = 1; BranchEn = 1; BranchSel = 2;
        step("halt");
        check("halt_pc", 32'(PC), 7);
        check("halt_done", 32'(Done), 1);
        check("halt_running", 32'(Running), 0);
        step("done_hold");
        check("done_hold_pc", 32'(PC), 7);
        Start = 1;
        step("restart");
        check("restart_pc", 32'(PC), 0);
        check("restart_done", 32'(Done), 0);
        Start = 1;
        step("start_in_run");
        check("start_in_run_pc", 32'(PC), 1);

        for (int i = 0; i < 400; i++) begin
            Start     = ($urandom_range(0, 9) == 0);
            Halt      = ($urandom_range(0, 24) == 0);
            Stall     = ($urandom_range(0, 4) == 0);
            BranchEn  = ($urandom_range(0, 3) == 0);
            BranchAbs = 1'($urandom);
            BranchSel = 4'($urandom);
            TgtWe     = ($urandom_range(0, 3) == 0);
            TgtAddr   = 4'($urandom);
            TgtData   = 8'($urandom);
            step("rand");
        end

        // Rewrite entry 5 so the reset revert below is observable.
        TgtWe = 1; TgtAddr = 5; TgtData = 8'hFE; Start = 1;
        step("pre_rst");
        Start = 1;
        step("pre_rst_start");
        jump_to(12);
        #2 Reset = 1;
        #1;
        check("arst_pc", 32'(PC), 0);
        check("arst_running", 32'(Running), 0);
        check("arst_done", 32'(Done), 0);
        model_reset();
        #3 Reset = 0;
        step("post_rst_idle");
        Start = 1;
        step("post_rst_start");
        jump_to(20);
        BranchEn = 1; BranchSel = 5;
        step("rst_entry5");
        check("rst_entry5_pc", 32'(PC), 20);
        BranchEn = 1; BranchAbs = 1; BranchSel = 2;
        step("rst_entry2");
        check("rst_entry2_pc", 32'(PC), 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
